// File: rtl/rle_pkg.sv
// Shared definitions for the RLE readback decoder: FSM states and SRAM entry layout.
package rle_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int SAMPLE_LSB  = 0;
    localparam int CNT_LSB     = 8;
    localparam int RLE_MAX_CNT = 255;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXPAND,
        FIN
    } state_t;

endpackage

// File: rtl/rle_entry_buf.sv
// One-entry prefetch holding register: filled by a returning SRAM read, drained when
// the decoder's current entry ends.
module rle_entry_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/rle_decoder.sv
// Expands {count, sample} entries read from capture SRAM into a valid/ready sample stream.
// Optional macro RLE_DEC_SAMPLE_TOTAL_EN adds the SAMPLE_TOTAL beat counter output.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  RLE_EN,
    input  logic [ADDR_W-1:0]     NUM_ENTRIES,
    input  logic [ADDR_W-1:0]     BASE_ADDR,
    output logic                  SRAM_RD,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    input  logic [8+CNT_W-1:0]    SRAM_RDATA,
    input  logic                  SRAM_RVALID,
    output logic [7:0]            OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic                  DONE
`ifdef RLE_DEC_SAMPLE_TOTAL_EN
    ,
    output logic [ADDR_W+CNT_W:0] SAMPLE_TOTAL
`endif
);

    localparam int ENT_W = SAMPLE_W + CNT_W;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic                rle_en_q, rle_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_left_q, rd_left_d;
    logic [SAMPLE_W-1:0] cur_smp_q, cur_smp_d;
    logic [CNT_W-1:0]    cur_cnt_q, cur_cnt_d;

    logic                rvalid_ok, beat, entry_end, issue;
    logic                buf_load, buf_pop, buf_full, buf_full_nx;
    logic [ENT_W-1:0]    rd_entry, buf_entry;

    // Returns with no read outstanding (e.g. after a reset) are dropped here.
    assign rvalid_ok = SRAM_RVALID && pend_q;
    assign beat      = (state_q == EXPAND) && OUT_READY;
    assign entry_end = beat && (cur_cnt_q == '0);
    assign rd_entry  = {rle_en_q ? SRAM_RDATA[CNT_LSB +: CNT_W] : {CNT_W{1'b0}},
                        SRAM_RDATA[SAMPLE_LSB +: SAMPLE_W]};

    always_comb begin
        buf_load  = 1'b0;
        buf_pop   = 1'b0;
        cur_smp_d = cur_smp_q;
        cur_cnt_d = cur_cnt_q;
        if (state_q == WAIT && rvalid_ok) begin
            {cur_cnt_d, cur_smp_d} = rd_entry;
        end else if (state_q == EXPAND) begin
            if (entry_end) begin
                if (buf_full) begin
                    {cur_cnt_d, cur_smp_d} = buf_entry;
                    buf_pop = 1'b1;
                end else if (rvalid_ok) begin
                    {cur_cnt_d, cur_smp_d} = rd_entry;
                end
            end else begin
                if (beat) begin
                    cur_cnt_d = cur_cnt_q - CNT_W'(1);
                end
                buf_load = rvalid_ok;
            end
        end
    end

    assign buf_full_nx = buf_load || (buf_full && !buf_pop);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        rle_en_d  = rle_en_q;
        addr_d    = addr_q;
        rd_left_d = rd_left_q;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    rle_en_d  = RLE_EN;
                    addr_d    = BASE_ADDR;
                    rd_left_d = NUM_ENTRIES;
                    state_d   = (NUM_ENTRIES == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                issue   = 1'b1;
                state_d = WAIT;
            end
            // A retiring read frees the single outstanding slot in the same cycle.
            WAIT, EXPAND: begin
                issue = (rd_left_q != '0) && (!pend_q || rvalid_ok) && !buf_full_nx;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            pend_d    = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
            rd_left_d = rd_left_q - ADDR_W'(1);
        end else if (rvalid_ok) begin
            pend_d = 1'b0;
        end
        if (state_q == WAIT && rvalid_ok) begin
            state_d = EXPAND;
        end
        if (entry_end && !buf_full && !rvalid_ok) begin
            state_d = pend_d ? WAIT : FIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            rle_en_q  <= 1'b0;
            addr_q    <= '0;
            rd_left_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            rle_en_q  <= rle_en_d;
            addr_q    <= addr_d;
            rd_left_q <= rd_left_d;
        end
    end

    always_ff @(posedge CLK) begin
        cur_smp_q <= cur_smp_d;
        cur_cnt_q <= cur_cnt_d;
    end

    rle_entry_buf #(
        .W(ENT_W)
    ) u_buf (
        .clk  (CLK),
        .rst  (RESET),
        .load (buf_load),
        .pop  (buf_pop),
        .din  (rd_entry),
        .full (buf_full),
        .dout (buf_entry)
    );

    assign SRAM_RD   = issue;
    assign SRAM_ADDR = issue ? addr_q : '0;
    assign OUT_VALID = (state_q == EXPAND);
    assign OUT_DATA  = OUT_VALID ? cur_smp_q : '0;
    assign BUSY      = (state_q == FETCH) || (state_q == WAIT) || (state_q == EXPAND);
    assign DONE      = (state_q == FIN);

`ifdef RLE_DEC_SAMPLE_TOTAL_EN
    logic [ADDR_W+CNT_W:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if (state_q == IDLE && START) begin
            total_d = '0;
        end else if (beat) begin
            total_d = total_q + (ADDR_W+CNT_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign SAMPLE_TOTAL = total_q;
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: table of readback runs plus hand-written
// sequences for empty runs and reset during expansion.
module tb_rle_decoder;
    import rle_pkg::*;

    localparam int ADDR_W = 19;
    localparam int CNT_W  = 8;

    logic              CLK = 1'b0;
    logic              RESET, START, RLE_EN;
    logic [ADDR_W-1:0] NUM_ENTRIES, BASE_ADDR;
    logic              SRAM_RD;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [15:0]       SRAM_RDATA;
    logic              SRAM_RVALID;
    logic [7:0]        OUT_DATA;
    logic              OUT_VALID, OUT_READY, BUSY, DONE;
`ifdef RLE_DEC_SAMPLE_TOTAL_EN
    logic [ADDR_W+CNT_W:0] SAMPLE_TOTAL;
`endif

    rle_decoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .RLE_EN      (RLE_EN),
        .NUM_ENTRIES (NUM_ENTRIES),
        .BASE_ADDR   (BASE_ADDR),
        .SRAM_RD     (SRAM_RD),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_RDATA  (SRAM_RDATA),
        .SRAM_RVALID (SRAM_RVALID),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .BUSY        (BUSY),
        .DONE        (DONE)
`ifdef RLE_DEC_SAMPLE_TOTAL_EN
        ,
        .SAMPLE_TOTAL(SAMPLE_TOTAL)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        int                num;
        bit                rle;
        int                lat;
        int                rmode;
        bit                restart;
        logic [3:0][15:0]  ent;
    } vec_t;

    vec_t vt [7];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] mem [int];
    logic [7:0] exp_q [$];
    logic [ADDR_W-1:0] exp_addr [$];
    int lat = 1;
    int resp_cnt = 0;
    logic [ADDR_W-1:0] resp_addr = '0;
    int rd_cnt = 0;
    int beats = 0, first_beat = 0, last_beat = 0;
    bit sb_en = 1'b1;
    int rmode = 0, pidx = 0;
    bit stall_prev = 1'b0;
    logic [7:0] hold_data = '0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [ADDR_W-1:0] b, input int n, input bit r,
                                input int l, input int m, input bit rs,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.base = b; v.num = n; v.rle = r; v.lat = l; v.rmode = m; v.restart = rs;
        v.ent[0] = e0; v.ent[1] = e1; v.ent[2] = e2; v.ent[3] = e3;
        return v;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM model: data returns lat cycles after the request cycle.
    initial begin
        SRAM_RVALID = 1'b0;
        SRAM_RDATA  = '0;
        forever begin
            @(negedge CLK);
            SRAM_RVALID = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    SRAM_RVALID = 1'b1;
                    SRAM_RDATA  = mem.exists(int'(resp_addr)) ? mem[int'(resp_addr)] : 16'hDEAD;
                end
            end
            #2;
            if (SRAM_RD) begin
                rd_cnt++;
                check("rd_overlap", resp_cnt, 0);
                if (exp_addr.size() == 0) check("rd_extra", 1, 0);
                else check("sram_addr", 32'(SRAM_ADDR), 32'(exp_addr.pop_front()));
                resp_cnt  = lat;
                resp_addr = SRAM_ADDR;
            end
        end
    end

    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rmode)
                1: begin
                    OUT_READY = (pidx % 4 == 0) || (pidx % 4 == 3);
                    pidx++;
                end
                2:       OUT_READY = 1'($urandom_range(0, 1));
                default: OUT_READY = 1'b1;
            endcase
        end
    end

    // Output monitor and scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (stall_prev) begin
                check("stall_hold_vld", 32'(OUT_VALID), 1);
                check("stall_hold_data", 32'(OUT_DATA), 32'(hold_data));
            end
            if (OUT_VALID && OUT_READY) begin
                beats++;
                if (beats == 1) first_beat = cyc;
                last_beat = cyc;
                if (sb_en) begin
                    if (exp_q.size() == 0) check("extra_beat", 1, 0);
                    else check("out_data", 32'(OUT_DATA), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = OUT_VALID && !OUT_READY;
            hold_data  = OUT_DATA;
        end
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input int n, input bit r);
        @(posedge CLK);
        #1;
        START = 1'b1; BASE_ADDR = b; NUM_ENTRIES = ADDR_W'(n); RLE_EN = r;
        @(posedge CLK);
        #1;
        START = 1'b0; BASE_ADDR = '0; NUM_ENTRIES = '0; RLE_EN = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int exp_beats = 0;
        int rd0;
        int done_cyc = -1;
        int c;
        logic [ADDR_W-1:0] a;
        lat = v.lat; rmode = v.rmode; pidx = 0; beats = 0; sb_en = 1'b1;
        for (int k = 0; k < v.num; k++) begin
            a = v.base + ADDR_W'(k);
            mem[int'(a)] = v.ent[k];
            exp_addr.push_back(a);
            c = v.rle ? int'(v.ent[k][15:8]) : 0;
            for (int j = 0; j <= c; j++) exp_q.push_back(v.ent[k][7:0]);
            exp_beats += c + 1;
        end
        rd0 = rd_cnt;
        pulse_start(v.base, v.num, v.rle);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #3;
            if (i == 0) check({tag, " busy"}, 32'(BUSY), 1);
            if (v.restart && i == 3) begin
                START = 1'b1; NUM_ENTRIES = ADDR_W'(7);
            end else begin
                START = 1'b0; NUM_ENTRIES = '0;
            end
            if (DONE) begin
                done_cyc = cyc;
                break;
            end
        end
        START = 1'b0;
        if (done_cyc < 0) check({tag, " done_timeout"}, 0, 1);
        check({tag, " busy_at_done"}, 32'(BUSY), 0);
        check({tag, " beats"}, beats, exp_beats);
        check({tag, " done_after_last"}, done_cyc, last_beat + 1);
        check({tag, " sb_left"}, exp_q.size(), 0);
        check({tag, " addr_left"}, exp_addr.size(), 0);
        check({tag, " reads"}, rd_cnt - rd0, v.num);
        if (v.lat == 1 && v.rmode == 0) check({tag, " no_gaps"}, last_beat - first_beat, exp_beats - 1);
`ifdef RLE_DEC_SAMPLE_TOTAL_EN
        check({tag, " total"}, 32'(SAMPLE_TOTAL), exp_beats);
`endif
        @(negedge CLK);
        #3;
        check({tag, " done_pulse"}, 32'(DONE), 0);
        exp_q.delete();
        exp_addr.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        bit seen;
        RESET = 1'b1; START = 1'b0; RLE_EN = 1'b0; NUM_ENTRIES = '0; BASE_ADDR = '0;
        vt[0] = mk(19'h00000, 3, 1, 1, 0, 0, 16'h00A5, 16'h023C, 16'h00FF, 16'h0);
        vt[1] = mk(19'h00100, 1, 1, 1, 0, 0, {8'(RLE_MAX_CNT), 8'h11}, 16'h0, 16'h0, 16'h0);
        vt[2] = mk(19'h00010, 3, 0, 1, 0, 0, 16'h00A5, 16'h023C, 16'h00FF, 16'h0);
        vt[3] = mk(19'h7FFFF, 2, 1, 2, 0, 0, 16'h015A, 16'h0066, 16'h0, 16'h0);
        vt[4] = mk(19'h00040, 4, 1, 3, 2, 1, 16'h0001, 16'h0002, 16'h0103, 16'h0304);
        vt[5] = mk(19'h00200, 3, 1, 1, 0, 0, 16'h0010, 16'h0020, 16'h0030, 16'h0);
        vt[6] = mk(19'h00300, 1, 1, 1, 1, 0, 16'h0342, 16'h0, 16'h0, 16'h0);

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        #3;
        check("rst_out_valid", 32'(OUT_VALID), 0);
        check("rst_out_data", 32'(OUT_DATA), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_sram_rd", 32'(SRAM_RD), 0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 0);
`ifdef RLE_DEC_SAMPLE_TOTAL_EN
        check("rst_total", 32'(SAMPLE_TOTAL), 0);
`endif

        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Empty run: straight to DONE, no SRAM traffic.
        rd0 = rd_cnt;
        pulse_start(19'h00123, 0, 1'b1);
        @(negedge CLK);
        #3;
        check("num0 done", 32'(DONE), 1);
        @(negedge CLK);
        #3;
        check("num0 done_pulse", 32'(DONE), 0);
        check("num0 reads", rd_cnt - rd0, 0);

        // Reset during expansion with the prefetch read still in flight.
        lat = 4; rmode = 0; sb_en = 1'b0;
        mem[32'h500] = 16'h0377;
        mem[32'h501] = 16'h0088;
        exp_addr.push_back(19'h00500);
        exp_addr.push_back(19'h00501);
        pulse_start(19'h00500, 2, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            #3;
            if (OUT_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid expand_reached", 32'(seen), 1);
        check("rstmid read_outstanding", 32'(resp_cnt > 0), 1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        #3;
        check("rstmid out_valid", 32'(OUT_VALID), 0);
        check("rstmid out_data", 32'(OUT_DATA), 0);
        check("rstmid busy", 32'(BUSY), 0);
        check("rstmid done", 32'(DONE), 0);
        check("rstmid sram_rd", 32'(SRAM_RD), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            #3;
            check("rstmid late_valid", 32'(OUT_VALID), 0);
            check("rstmid late_busy", 32'(BUSY), 0);
        end
        check("rstmid addr_left", exp_addr.size(), 0);
        exp_addr.delete();
        exp_q.delete();
        run_vec(vt[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
